// File: rtl/stage_sequencer_if.sv
// Handshake bundle for stage_sequencer: sequence control in, per-stage enables and status out.
interface stage_sequencer_if #(
  parameter int unsigned NUM_STAGES = 4
);
  logic                  in_start;
  logic                  in_abort;
  logic                  in_loop;
  logic [NUM_STAGES-1:0] in_skip_mask;
  logic [NUM_STAGES-1:0] in_stage_done;
  logic [NUM_STAGES-1:0] out_stage_en;
  logic [3:0]            out_current_stage;
  logic                  out_busy;
  logic                  out_process_done;
  logic                  out_error;
  logic [15:0]           out_frame_count;

  modport master (
    output in_start, in_abort, in_loop, in_skip_mask, in_stage_done,
    input  out_stage_en, out_current_stage, out_busy, out_process_done,
           out_error, out_frame_count
  );

  modport slave (
    input  in_start, in_abort, in_loop, in_skip_mask, in_stage_done,
    output out_stage_en, out_current_stage, out_busy, out_process_done,
           out_error, out_frame_count
  );
endinterface

// File: rtl/stage_sequencer.sv
// Steps through NUM_STAGES processing stages one at a time with a one-cycle gap between them.
// Optional per-stage RUN timeout enabled by defining STAGE_SEQUENCER_TIMEOUT_EN.
module stage_sequencer #(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input logic              clock,
  input logic              reset,
  stage_sequencer_if.slave sif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state;
  logic [NUM_STAGES-1:0] mask_q;
  logic                  loop_q;
  logic [3:0]            stage_q;
  logic [NUM_STAGES-1:0] stage_en_q;
  logic                  busy_q;
  logic                  done_q;
  logic [15:0]           frame_q;

  // Result encoding: bit 4 = an unskipped stage was found, bits 3:0 = its index.
  logic [4:0] first_in;
  logic [4:0] first_q;
  logic [4:0] next_q;
  logic       start_ok;
  logic       stage_hit;

  function automatic logic [4:0] find_from(input logic [NUM_STAGES-1:0] m,
                                           input logic [4:0]            from);
    logic [4:0]            r;
    logic [NUM_STAGES-1:0] sh;
    r = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      sh = m >> i;
      if (!r[4] && !sh[0] && (i >= 32'(from))) begin
        r = {1'b1, 4'(i)};
      end
    end
    return r;
  endfunction

  function automatic logic [NUM_STAGES-1:0] onehot(input logic [3:0] idx);
    return NUM_STAGES'(1) << idx;
  endfunction

  always_comb begin
    first_in = find_from(sif.in_skip_mask, 5'd0);
    first_q  = find_from(mask_q, 5'd0);
    next_q   = find_from(mask_q, {1'b0, stage_q} + 5'd1);
  end

  assign start_ok  = sif.in_start &&
                     ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  // The enable register is one-hot on the active stage, so masking the done flags with it
  // ignores every non-active stage.
  assign stage_hit = |(sif.in_stage_done & stage_en_q);

`ifdef STAGE_SEQUENCER_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer_q;
  logic          timeout_hit;
  logic          error_q;

  assign timeout_hit = (timer_q == TIMER_LAST);

  // RUN is only ever entered from a non-RUN state, so clearing outside RUN clears on entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else if (state != S_RUN) begin
      timer_q <= '0;
    end else if (!timeout_hit) begin
      timer_q <= timer_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      mask_q     <= '0;
      loop_q     <= 1'b0;
      stage_q    <= '0;
      stage_en_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      frame_q    <= '0;
`ifdef STAGE_SEQUENCER_TIMEOUT_EN
      error_q    <= 1'b0;
`endif
    end else if (sif.in_abort) begin
      state      <= S_IDLE;
      stage_en_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef STAGE_SEQUENCER_TIMEOUT_EN
      error_q    <= 1'b0;
`endif
    end else if (start_ok) begin
      mask_q <= sif.in_skip_mask;
      loop_q <= sif.in_loop;
`ifdef STAGE_SEQUENCER_TIMEOUT_EN
      error_q <= 1'b0;
`endif
      if (first_in[4]) begin
        state      <= S_RUN;
        stage_q    <= first_in[3:0];
        stage_en_q <= onehot(first_in[3:0]);
        busy_q     <= 1'b1;
        done_q     <= 1'b0;
      end else begin
        state      <= S_DONE;
        stage_en_q <= '0;
        busy_q     <= 1'b0;
        done_q     <= 1'b1;
        frame_q    <= frame_q + 1'b1;
      end
    end else begin
      case (state)
        S_RUN: begin
          if (stage_hit) begin
            state      <= S_GAP;
            stage_en_q <= '0;
          end
`ifdef STAGE_SEQUENCER_TIMEOUT_EN
          else if (timeout_hit) begin
            state      <= S_ERROR;
            stage_en_q <= '0;
            busy_q     <= 1'b0;
            error_q    <= 1'b1;
          end
`endif
        end

        S_GAP: begin
          if (next_q[4]) begin
            state      <= S_RUN;
            stage_q    <= next_q[3:0];
            stage_en_q <= onehot(next_q[3:0]);
          end else begin
            state   <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            frame_q <= frame_q + 1'b1;
          end
        end

        S_DONE: begin
          // Loop mode re-enters DONE directly when every stage is skipped, counting each pass.
          if (loop_q) begin
            if (first_q[4]) begin
              state      <= S_RUN;
              stage_q    <= first_q[3:0];
              stage_en_q <= onehot(first_q[3:0]);
              busy_q     <= 1'b1;
              done_q     <= 1'b0;
            end else begin
              frame_q <= frame_q + 1'b1;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign sif.out_stage_en      = stage_en_q;
  assign sif.out_current_stage = stage_q;
  assign sif.out_busy          = busy_q;
  assign sif.out_process_done  = done_q;
  assign sif.out_frame_count   = frame_q;
`ifdef STAGE_SEQUENCER_TIMEOUT_EN
  assign sif.out_error         = error_q;
`else
  assign sif.out_error         = 1'b0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed self-checking bench for stage_sequencer (NUM_STAGES=4, TIMEOUT_CYCLES=8).
module tb_stage_sequencer;
  localparam int unsigned N = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  stage_sequencer_if #(.NUM_STAGES(N)) sif ();

  stage_sequencer #(
    .NUM_STAGES(N),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sif(sif.slave)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [3:0]  onehot_tbl [N] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #2;
    chk16("rst_pulse_fc", sif.out_frame_count, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int unsigned guard;
    sif.in_start      = 1'b0;
    sif.in_abort      = 1'b0;
    sif.in_loop       = 1'b0;
    sif.in_skip_mask  = '0;
    sif.in_stage_done = '0;
    #2;
    chk4 ("rst_en",   sif.out_stage_en,      4'b0000);
    chk4 ("rst_cur",  sif.out_current_stage, 4'h0);
    chk1 ("rst_busy", sif.out_busy,          1'b0);
    chk1 ("rst_pd",   sif.out_process_done,  1'b0);
    chk1 ("rst_err",  sif.out_error,         1'b0);
    chk16("rst_fc",   sif.out_frame_count,   16'h0000);
    @(negedge clock);
    reset = 1'b0;

    // Full four-stage sequence, each done three cycles after its enable.
    sif.in_skip_mask = 4'b0000;
    sif.in_loop      = 1'b0;
    sif.in_start     = 1'b1;
    tick();
    sif.in_start = 1'b0;
    chk4("A_first_en", sif.out_stage_en, 4'b0001);
    chk1("A_busy",     sif.out_busy,     1'b1);
    for (int s = 0; s < 4; s++) begin
      tick();
      tick();
      chk4($sformatf("A_hold_en%0d", s), sif.out_stage_en, onehot_tbl[s]);
      chk4($sformatf("A_cur%0d", s), sif.out_current_stage, 4'(s));
      sif.in_stage_done = onehot_tbl[s];
      tick();
      sif.in_stage_done = '0;
      chk4($sformatf("A_gap_en%0d", s), sif.out_stage_en, 4'b0000);
      chk1($sformatf("A_gap_busy%0d", s), sif.out_busy, 1'b1);
      tick();
      if (s < 3) begin
        chk4($sformatf("A_next_en%0d", s), sif.out_stage_en, onehot_tbl[s+1]);
      end else begin
        chk1 ("A_pd",      sif.out_process_done, 1'b1);
        chk1 ("A_busy_dn", sif.out_busy,         1'b0);
        chk4 ("A_en_dn",   sif.out_stage_en,     4'b0000);
        chk16("A_fc",      sif.out_frame_count,  16'h0001);
      end
    end
    repeat (3) tick();
    chk1 ("A_pd_hold", sif.out_process_done, 1'b1);
    chk16("A_fc_hold", sif.out_frame_count,  16'h0001);
    chk4 ("A_en_hold", sif.out_stage_en,     4'b0000);

    // Mask 0101: only stages 1 and 3; start during RUN and foreign done flags ignored.
    sif.in_skip_mask = 4'b0101;
    sif.in_start     = 1'b1;
    tick();
    sif.in_start = 1'b0;
    chk4("B_en1",  sif.out_stage_en,      4'b0010);
    chk4("B_cur1", sif.out_current_stage, 4'h1);
    chk1("B_pd0",  sif.out_process_done,  1'b0);
    chk1("B_busy", sif.out_busy,          1'b1);
    sif.in_start     = 1'b1;
    sif.in_skip_mask = 4'b1111;
    tick();
    sif.in_start     = 1'b0;
    sif.in_skip_mask = 4'b0101;
    chk4("B_start_ign", sif.out_stage_en, 4'b0010);
    sif.in_stage_done = 4'b0010;
    tick();
    sif.in_stage_done = '0;
    chk4("B_gap", sif.out_stage_en, 4'b0000);
    tick();
    chk4("B_en3",  sif.out_stage_en,      4'b1000);
    chk4("B_cur3", sif.out_current_stage, 4'h3);
    sif.in_stage_done = 4'b0111;
    tick();
    chk4("B_foreign_ign", sif.out_stage_en, 4'b1000);
    sif.in_stage_done = 4'b1000;
    tick();
    sif.in_stage_done = '0;
    chk4("B_gap2", sif.out_stage_en, 4'b0000);
    tick();
    chk1 ("B_pd",     sif.out_process_done,  1'b1);
    chk16("B_fc",     sif.out_frame_count,   16'h0002);
    chk4 ("B_cur_dn", sif.out_current_stage, 4'h3);
    chk4 ("B_en_dn",  sif.out_stage_en,      4'b0000);

    // All stages skipped: DONE on the next edge.
    sif.in_skip_mask = 4'b1111;
    sif.in_start     = 1'b1;
    tick();
    sif.in_start = 1'b0;
    chk1 ("C_pd",   sif.out_process_done, 1'b1);
    chk4 ("C_en",   sif.out_stage_en,     4'b0000);
    chk1 ("C_busy", sif.out_busy,         1'b0);
    chk16("C_fc",   sif.out_frame_count,  16'h0003);
    tick();
    chk16("C_fc_hold", sif.out_frame_count, 16'h0003);
    chk4 ("C_en_hold", sif.out_stage_en,    4'b0000);

    // Loop mode: three sequences, then abort together with stage 2 done.
    do_reset();
    sif.in_skip_mask = 4'b0000;
    sif.in_loop      = 1'b1;
    sif.in_start     = 1'b1;
    tick();
    sif.in_start = 1'b0;
    sif.in_loop  = 1'b0;
    for (int seq = 1; seq <= 3; seq++) begin
      for (int s = 0; s < 4; s++) begin
        chk4($sformatf("D_en_q%0d_s%0d", seq, s), sif.out_stage_en, onehot_tbl[s]);
        sif.in_stage_done = onehot_tbl[s];
        tick();
        sif.in_stage_done = '0;
        chk4($sformatf("D_gap_q%0d_s%0d", seq, s), sif.out_stage_en, 4'b0000);
        tick();
      end
      chk1 ($sformatf("D_pd_q%0d", seq), sif.out_process_done, 1'b1);
      chk16($sformatf("D_fc_q%0d", seq), sif.out_frame_count, 16'(seq));
      tick();
      chk1($sformatf("D_pd_off_q%0d", seq), sif.out_process_done, 1'b0);
    end
    for (int s = 0; s < 2; s++) begin
      chk4($sformatf("D_run4_en%0d", s), sif.out_stage_en, onehot_tbl[s]);
      sif.in_stage_done = onehot_tbl[s];
      tick();
      sif.in_stage_done = '0;
      tick();
    end
    chk4("D_en2", sif.out_stage_en, 4'b0100);
    sif.in_abort      = 1'b1;
    sif.in_stage_done = 4'b0100;
    tick();
    sif.in_abort      = 1'b0;
    sif.in_stage_done = '0;
    chk4 ("D_abort_en",   sif.out_stage_en,     4'b0000);
    chk1 ("D_abort_busy", sif.out_busy,         1'b0);
    chk1 ("D_abort_pd",   sif.out_process_done, 1'b0);
    chk1 ("D_abort_err",  sif.out_error,        1'b0);
    chk16("D_abort_fc",   sif.out_frame_count,  16'h0003);
    tick();
    chk4("D_idle_en",   sif.out_stage_en, 4'b0000);
    chk1("D_idle_busy", sif.out_busy,     1'b0);

`ifdef STAGE_SEQUENCER_TIMEOUT_EN
    // Stage 0 never completes: ERROR after 8 RUN cycles, start recovers.
    sif.in_skip_mask = 4'b0000;
    sif.in_start     = 1'b1;
    tick();
    sif.in_start = 1'b0;
    chk4("E_en0", sif.out_stage_en, 4'b0001);
    repeat (7) tick();
    chk4("E_en7",  sif.out_stage_en, 4'b0001);
    chk1("E_err7", sif.out_error,    1'b0);
    tick();
    chk1("E_err",      sif.out_error,    1'b1);
    chk4("E_err_en",   sif.out_stage_en, 4'b0000);
    chk1("E_err_busy", sif.out_busy,     1'b0);
    tick();
    chk1("E_err_hold", sif.out_error, 1'b1);
    sif.in_start = 1'b1;
    tick();
    sif.in_start = 1'b0;
    chk4("E_restart_en",  sif.out_stage_en,      4'b0001);
    chk1("E_restart_err", sif.out_error,         1'b0);
    chk4("E_restart_cur", sif.out_current_stage, 4'h0);
`else
    // Without the timeout feature RUN waits indefinitely and error never rises.
    sif.in_skip_mask = 4'b0000;
    sif.in_start     = 1'b1;
    tick();
    sif.in_start = 1'b0;
    repeat (20) tick();
    chk4("E_wait_en",   sif.out_stage_en, 4'b0001);
    chk1("E_wait_err",  sif.out_error,    1'b0);
    chk1("E_wait_busy", sif.out_busy,     1'b1);
`endif
    sif.in_abort = 1'b1;
    tick();
    sif.in_abort = 1'b0;

    // Asynchronous reset between edges during RUN.
    sif.in_start = 1'b1;
    tick();
    sif.in_start = 1'b0;
    chk4("F_en_pre", sif.out_stage_en, 4'b0001);
    #3;
    reset = 1'b1;
    #2;
    chk4 ("F_en",   sif.out_stage_en,      4'b0000);
    chk1 ("F_busy", sif.out_busy,          1'b0);
    chk4 ("F_cur",  sif.out_current_stage, 4'h0);
    chk16("F_fc",   sif.out_frame_count,   16'h0000);
    @(negedge clock);
    reset = 1'b0;

    // Frame counter wrap: looping with every stage skipped counts one frame per cycle.
    sif.in_skip_mask = 4'b1111;
    sif.in_loop      = 1'b1;
    sif.in_start     = 1'b1;
    tick();
    sif.in_start = 1'b0;
    sif.in_loop  = 1'b0;
    chk16("G_fc1", sif.out_frame_count,  16'h0001);
    chk1 ("G_pd1", sif.out_process_done, 1'b1);
    guard = 0;
    while ((sif.out_frame_count !== 16'hFFFF) && (guard < 70000)) begin
      tick();
      guard++;
    end
    chk16("G_fc_ffff", sif.out_frame_count, 16'hFFFF);
    tick();
    chk16("G_fc_wrap", sif.out_frame_count,  16'h0000);
    chk1 ("G_pd_wrap", sif.out_process_done, 1'b1);
    sif.in_abort = 1'b1;
    tick();
    sif.in_abort = 1'b0;
    chk16("G_fc_abort", sif.out_frame_count,  16'h0000);
    chk1 ("G_pd_abort", sif.out_process_done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_STAGES, default 4, meaning the number of processing stages sequenced (range 1..16).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning the maximum RUN cycles allowed per stage before an error.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_start, input, 1 bit: a one-cycle request to begin a sequence.
REQ-006 The block SHALL have port in_abort, input, 1 bit: terminates any sequence.
REQ-007 The block SHALL have port in_loop, input, 1 bit: selects continuous mode, sampled with in_start.
REQ-008 The block SHALL have port in_skip_mask, input, NUM_STAGES bits: bit i=1 bypasses stage i, sampled with in_start.
REQ-009 The block SHALL have port in_stage_done, input, NUM_STAGES bits: the per-stage completion flags.
REQ-010 The block SHALL have port out_stage_en, output, NUM_STAGES bits: the per-stage enables, at most one bit high.
REQ-011 The block SHALL have port out_current_stage, output, 4 bits: the index of the active or last stage.
REQ-012 The block SHALL have port out_busy, output, 1 bit: high in the RUN and GAP states.
REQ-013 The block SHALL have port out_process_done, output, 1 bit: high in the DONE state.
REQ-014 The block SHALL have port out_error, output, 1 bit: high in the ERROR state.
REQ-015 The block SHALL have port out_frame_count, output, 16 bits: the number of completed sequences.

Function
REQ-016 The block SHALL implement states IDLE, RUN, GAP, DONE and ERROR; all outputs SHALL be registered.
REQ-017 IDLE, in_start=1: the block SHALL latch in_skip_mask and in_loop; if all stages are skipped it SHALL go to DONE, else to RUN at the lowest unskipped index.
REQ-018 RUN: out_stage_en SHALL equal one-hot(stage) and stay high until in_stage_done[stage]=1 is sampled, then go to GAP.
REQ-019 in_stage_done bits of non-active stages SHALL be ignored in every state.
REQ-020 GAP: out_stage_en SHALL be all zero for exactly one cycle, then go to RUN at the next higher unskipped index, or to DONE if none remains.
REQ-021 On entry to DONE, out_frame_count SHALL increment by 1, wrapping 0xFFFF to 0x0000.
REQ-022 DONE, latched loop=0: out_process_done SHALL hold high until in_start, then the block SHALL restart as in REQ-017 with out_process_done cleared.
REQ-023 DONE, latched loop=1: out_process_done SHALL be high for one cycle, then RUN at the first unskipped stage reusing the latched mask.
REQ-024 in_abort=1 in any state SHALL force IDLE on the next edge with all enables, out_process_done and out_error low; abort SHALL win over simultaneous in_start or in_stage_done.
REQ-025 in_start outside IDLE, DONE and ERROR SHALL be ignored.
REQ-026 A stage done and a timeout on the same cycle SHALL be treated as done.
REQ-027 Minimum latency SHALL be one cycle from in_start to the first enable, and one RUN cycle plus one GAP cycle per active stage.

Reset
REQ-028 When reset=1 (asynchronous) the block SHALL enter IDLE with out_stage_en=0, out_current_stage=0, out_busy=0, out_process_done=0, out_error=0, out_frame_count=0 and the latched mask and loop cleared.
REQ-029 Reset mid-sequence SHALL drop every enable immediately, without waiting for a clock edge.

Configuration
REQ-030 With macro STAGE_SEQUENCER_TIMEOUT_EN defined: a per-stage counter SHALL clear on RUN entry, and reaching TIMEOUT_CYCLES without done SHALL move the block to ERROR with enables low and out_error=1, held until in_abort or in_start (restart).
REQ-031 Without STAGE_SEQUENCER_TIMEOUT_EN: no counter SHALL exist, RUN SHALL wait indefinitely, and out_error SHALL be tied 0.

Verification
REQ-032 NUM_STAGES=4, mask=0000, loop=0, start, each done 3 cycles after its enable -> enables 0001, 0010, 0100, 1000 in order, each separated by one zero cycle; process_done then stays high and frame_count=1.
REQ-033 mask=0101, start -> only stages 1 and 3 are enabled; current_stage shows 1 then 3; done is reached.
REQ-034 mask=1111, start -> DONE on the next cycle with no enable ever high and frame_count incremented.
REQ-035 loop=1, four stages, 3 sequences run, then abort asserted during stage 2 together with its done -> process_done pulses 3 times, frame_count=3, IDLE next edge, no GAP.
REQ-036 TIMEOUT_EN defined, TIMEOUT_CYCLES=8, stage 0 done never asserted -> error=1 after 8 RUN cycles with enables 0; a later start restarts at stage 0 with error cleared.
REQ-037 reset pulsed during RUN (between clock edges) -> enables go 0 at once; frame_count preload 0xFFFF plus one sequence -> 0x0000.
